stream_run_ctrl: RTL and testbench

Sequences one coprocessor run over a streaming datapath. The host issues start with a token count. The block gates the AXI-Stream input handshake into the datapath and counts accepted input and output beats. It generates m_axis_tlast on the final output beat and pulses done when the run completes. Data buses bypass this block; it owns only valid/ready/last and status.

---
 rtl/stream_run_pkg.sv | 17 +
 rtl/beat_counter.sv | 31 +++
 rtl/stream_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_stream_run_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_run_pkg.sv
// Shared types for the coprocessor run sequencer: FSM state encoding and
// error-flag bit positions.
package stream_run_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ERR_SIZE0 = 0;
  localparam int ERR_TLAST = 1;

endpackage

// File: rtl/beat_counter.sv
// Beat counter with synchronous clear and a last-beat flag against a run limit.
module beat_counter #(
  parameter int SIZE = 12
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] lim,
  output logic [SIZE-1:0] count,
  output logic            at_last
);

  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  // Count accepted beats; clear has priority over increment.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= {SIZE{1'b0}};
    end else if (clr) begin
      count <= {SIZE{1'b0}};
    end else if (en) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign at_last = (count == (lim - ONE));

endmodule

// File: rtl/stream_run_ctrl.sv
// Run sequencer: gates the stream handshakes around a datapath for one run of
// a host-specified token count, generating tlast, done and sticky errors.
module stream_run_ctrl
  import stream_run_pkg::*;
#(
  parameter int SIZE = 12
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic            abort,
  input  logic [SIZE-1:0] size,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic            s_axis_tlast,
  output logic            dp_in_valid,
  input  logic            dp_in_ready,
  input  logic            dp_out_valid,
  output logic            dp_out_ready,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err,
  output logic [SIZE-1:0] in_cnt,
  output logic [SIZE-1:0] out_cnt
);

  state_e          state_r;
  logic [SIZE-1:0] size_r;

  logic in_open_s, out_open_s, out_full_s;
  logic in_beat_s, out_beat_s;
  logic in_at_last_s, out_at_last_s;
  logic accept_s, cnt_clr_s;
  logic in_done_s, out_done_s;

  assign accept_s   = (state_r == IDLE) && start && (size != {SIZE{1'b0}});
  assign cnt_clr_s  = abort | accept_s;
  assign out_full_s = (out_cnt == size_r);
  assign in_beat_s  = s_axis_tvalid & s_axis_tready;
  assign out_beat_s = m_axis_tvalid & m_axis_tready;
  assign in_done_s  = in_beat_s & in_at_last_s;
  // Output side is finished either already full or completing on this beat.
  assign out_done_s = out_full_s | (out_beat_s & out_at_last_s);

  // Handshake gating: pass-through while the corresponding path is open.
  always_comb begin
    in_open_s     = (state_r == RUN);
    out_open_s    = ((state_r == RUN) || (state_r == DRAIN)) && !out_full_s;
    s_axis_tready = in_open_s & dp_in_ready;
    dp_in_valid   = in_open_s & s_axis_tvalid;
    m_axis_tvalid = out_open_s & dp_out_valid;
    dp_out_ready  = out_open_s & m_axis_tready;
    m_axis_tlast  = m_axis_tvalid & out_at_last_s;
  end

  beat_counter #(.SIZE(SIZE)) u_in_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (cnt_clr_s),
    .en      (in_beat_s),
    .lim     (size_r),
    .count   (in_cnt),
    .at_last (in_at_last_s)
  );

  beat_counter #(.SIZE(SIZE)) u_out_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (cnt_clr_s),
    .en      (out_beat_s),
    .lim     (size_r),
    .count   (out_cnt),
    .at_last (out_at_last_s)
  );

  // Run FSM with registered busy/done/err status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      size_r  <= {SIZE{1'b0}};
      err     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (size == {SIZE{1'b0}})) begin
            err[ERR_SIZE0] <= 1'b1;
          end else if (start) begin
            size_r  <= size;
            err     <= 2'b00;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // tlast must be high exactly on the final input beat.
          if (in_beat_s && (s_axis_tlast != in_at_last_s)) begin
            err[ERR_TLAST] <= 1'b1;
          end else begin
            err <= err;
          end
          if (in_done_s && out_done_s) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (in_done_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (out_done_s) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_run_ctrl.sv
// Randomized bench for stream_run_ctrl against a token-count reference model
// with a latency-queue datapath.
module tb_stream_run_ctrl;

  localparam int SIZE = 12;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            start, abort;
  logic [SIZE-1:0] size;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic            dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic            busy, done;
  logic [1:0]      err;
  logic [SIZE-1:0] in_cnt, out_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // datapath model and stimulus knobs
  logic comb_mode = 1'b0;
  logic dp_out_valid_q = 1'b0;
  logic dp_in_ready_q = 1'b0;
  int   q[$];
  int   lat = 2;
  int   vprob = 100;
  int   dprob = 100;
  int   rmode = 0;
  int   bad_beat = -1;

  // reference model: run as a pair of token counts against a target
  bit         m_run = 1'b0;
  bit         m_done = 1'b0;
  int         m_size = 0;
  int         m_in = 0;
  int         m_out = 0;
  logic [1:0] m_err = 2'b00;

  // observed event counters
  int done_cnt = 0;
  int tlast_cnt = 0;
  int obeat_cnt = 0;

  assign dp_out_valid = comb_mode ? dp_in_valid : dp_out_valid_q;
  assign dp_in_ready  = comb_mode ? m_axis_tready : dp_in_ready_q;

  always #5 aclk = ~aclk;

  stream_run_ctrl #(.SIZE(SIZE)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort), .size(size),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .err(err), .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  // One clock of stimulus, model update and comparison; entered at posedge+1.
  task automatic step();
    logic in_open, out_open, e_dpiv, e_str, e_mtv, e_dor, e_tl, e_ib, e_ob;
    logic [4:0] e_hs, a_hs;
    bit done_n;
    s_axis_tvalid  = ($urandom_range(99) < vprob);
    s_axis_tlast   = ((m_in == m_size - 1) != (m_in == bad_beat));
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_axis_tready = ($urandom_range(1) == 1);
    endcase
    dp_in_ready_q  = ($urandom_range(99) < dprob);
    dp_out_valid_q = (q.size() > 0) && (q[0] <= cyc);
    #4;
    in_open  = m_run && (m_in < m_size);
    out_open = m_run && (m_out < m_size);
    e_dpiv = in_open & s_axis_tvalid;
    e_str  = in_open & (comb_mode ? m_axis_tready : dp_in_ready_q);
    e_mtv  = out_open & (comb_mode ? e_dpiv : dp_out_valid_q);
    e_dor  = out_open & m_axis_tready;
    e_tl   = e_mtv && (m_out == m_size - 1);
    e_hs   = {e_str, e_dpiv, e_mtv, e_dor, e_tl};
    a_hs   = {s_axis_tready, dp_in_valid, m_axis_tvalid, dp_out_ready, m_axis_tlast};
    checks++;
    if (a_hs !== e_hs) begin
      failures++;
      $display("FAIL handshake cyc=%0d got=%b want=%b (tready,dpiv,mtvalid,dpoready,tlast)", cyc, a_hs, e_hs);
    end
    e_ib = s_axis_tvalid & e_str;
    e_ob = e_mtv & m_axis_tready;
    if (m_axis_tvalid && m_axis_tready) obeat_cnt++;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) tlast_cnt++;
    @(posedge aclk);
    cyc++;
    if (!comb_mode) begin
      if (e_ob && q.size() > 0) void'(q.pop_front());
      if (e_ib) q.push_back(cyc + lat);
    end
    done_n = 1'b0;
    if (abort) begin
      m_run = 1'b0; m_in = 0; m_out = 0;
    end else if (!m_run && !m_done && start) begin
      if (size == '0) m_err[0] = 1'b1;
      else begin
        m_run = 1'b1; m_size = int'(size); m_in = 0; m_out = 0; m_err = 2'b00;
      end
    end else if (m_run) begin
      if (e_ib) begin
        if (s_axis_tlast != (m_in == m_size - 1)) m_err[1] = 1'b1;
        m_in++;
      end
      if (e_ob) m_out++;
      if (m_in == m_size && m_out == m_size) begin
        m_run = 1'b0; done_n = 1'b1;
      end
    end
    m_done = done_n;
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (done) done_cnt++;
    checks++;
    if ({busy, done, err, in_cnt, out_cnt} !== {m_run, m_done, m_err, SIZE'(m_in), SIZE'(m_out)}) begin
      failures++;
      $display("FAIL status cyc=%0d got busy=%b done=%b err=%b in=%0d out=%0d want busy=%b done=%b err=%b in=%0d out=%0d",
               cyc, busy, done, err, in_cnt, out_cnt, m_run, m_done, m_err, m_in, m_out);
    end
  endtask

  task automatic launch(input int n);
    start = 1'b1;
    size  = SIZE'(n);
    step();
  endtask

  task automatic run_to_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!m_run && !m_done) break;
      step();
    end
    checks++;
    if (m_run || m_done) begin
      failures++;
      $display("FAIL timeout run still active after %0d cycles", limit);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_in = 0; m_out = 0; m_err = 2'b00; m_size = 0;
    q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #2;
    checks++;
    if ({s_axis_tready, dp_in_valid, m_axis_tvalid, dp_out_ready, m_axis_tlast, busy, done, err, in_cnt, out_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got hs=%b busy=%b done=%b err=%b in=%0d out=%0d want all zero",
               {s_axis_tready, dp_in_valid, m_axis_tvalid, dp_out_ready, m_axis_tlast}, busy, done, err, in_cnt, out_cnt);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0, t0, o0;
    d0 = done_cnt; t0 = tlast_cnt; o0 = obeat_cnt;
    vprob = 100; dprob = 100; rmode = 0; lat = 2;
    launch(4);
    run_to_done(100);
    step();
    checks++;
    if (obeat_cnt - o0 != 4 || tlast_cnt - t0 != 1 || done_cnt - d0 != 1 || err !== 2'b00) begin
      failures++;
      $display("FAIL basic got beats=%0d tlast=%0d done=%0d err=%b want 4 1 1 00",
               obeat_cnt - o0, tlast_cnt - t0, done_cnt - d0, err);
    end
  endtask

  task automatic test_size_zero();
    int d0;
    d0 = done_cnt;
    launch(0);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (err !== 2'b01 || busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL size_zero got err=%b busy=%b done=%0d want 01 0 0", err, busy, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int t0, o0;
    t0 = tlast_cnt; o0 = obeat_cnt;
    vprob = 60; dprob = 80; rmode = 1; lat = 3;
    launch(8);
    step(); step();
    launch(2);
    run_to_done(300);
    checks++;
    if (obeat_cnt - o0 != 8 || tlast_cnt - t0 != 1 || out_cnt !== 12'd8) begin
      failures++;
      $display("FAIL backpressure got beats=%0d tlast=%0d out_cnt=%0d want 8 1 8", obeat_cnt - o0, tlast_cnt - t0, out_cnt);
    end
  endtask

  task automatic test_abort();
    int d0;
    vprob = 100; dprob = 100; rmode = 2; lat = 2;
    launch(6);
    for (int i = 0; i < 50 && m_in < 3; i++) step();
    d0 = done_cnt;
    abort = 1'b1;
    step();
    q.delete();
    step();
    checks++;
    if (busy !== 1'b0 || in_cnt !== 12'd0 || done_cnt != d0) begin
      failures++;
      $display("FAIL abort got busy=%b in_cnt=%0d done=%0d want 0 0 0", busy, in_cnt, done_cnt - d0);
    end
    d0 = done_cnt;
    launch(2);
    run_to_done(100);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL abort_restart got done=%0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_tlast_err();
    int d0;
    d0 = done_cnt;
    vprob = 80; dprob = 100; rmode = 2; lat = 1;
    bad_beat = 1;
    launch(3);
    run_to_done(100);
    bad_beat = -1;
    checks++;
    if (err[1] !== 1'b1 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL tlast_err got err=%b done=%0d want err[1]=1 done=1", err, done_cnt - d0);
    end
    launch(3);
    checks++;
    if (err !== 2'b00) begin
      failures++;
      $display("FAIL err_clear got err=%b want 00", err);
    end
    run_to_done(100);
  endtask

  task automatic test_comb();
    vprob = 100; rmode = 0;
    comb_mode = 1'b1;
    launch(1);
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL comb_direct got done=%b busy=%b want 1 0", done, busy);
    end
    step();
    launch(4095);
    run_to_done(4200);
    checks++;
    if (in_cnt !== 12'hFFF || out_cnt !== 12'hFFF) begin
      failures++;
      $display("FAIL max_size got in=%0d out=%0d want 4095 4095", in_cnt, out_cnt);
    end
    comb_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    vprob = 100; dprob = 100; rmode = 0; lat = 2;
    launch(5);
    step(); step();
    aresetn = 1'b0;
    #2;
    checks++;
    if ({busy, s_axis_tready, m_axis_tvalid, in_cnt, out_cnt, err} !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%b tready=%b mtvalid=%b in=%0d out=%0d err=%b want all zero",
               busy, s_axis_tready, m_axis_tvalid, in_cnt, out_cnt, err);
    end
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; size = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    test_reset();
    test_basic();
    test_size_zero();
    test_backpressure();
    test_abort();
    test_tlast_err();
    test_comb();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
